fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC and instruction width.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, SHALL set the instruction-queue depth and the outstanding-request budget.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC loaded at reset.
REQ-004 Parameter NOP_INSTR, default 32'h0000_0013, SHALL set the instruction driven when no valid instruction is presented.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  XLEN  fetch address, equal to the current fetch PC.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_rsp_valid  input  1  in-order response valid; memory never back-pressures responses.
REQ-011 imem_rsp_data  input  XLEN  fetched instruction.
REQ-012 redirect_valid  input  1  branch/jump redirect from execute.
REQ-013 redirect_pc  input  XLEN  redirect target.
REQ-014 valid_d  output  1  decode-side instruction valid.
REQ-015 ready_d  input  1  decode accepts the head instruction.
REQ-016 instr_d, pc_d, pcplus4_d  output  XLEN each  head instruction, its PC, and PC+4.

Function
REQ-017 A request SHALL be accepted when imem_req_valid and imem_req_ready are both high; the fetch PC SHALL then advance by 4, wrapping modulo 2^XLEN.
REQ-018 imem_req_valid SHALL be high only when (outstanding + queue count) < DEPTH and redirect_valid is low, so the queue can never overflow.
REQ-019 Each non-dropped response SHALL be pushed into the queue with its PC and PC+4; the PC SHALL come from an internal PC-tag FIFO written when the request is accepted.
REQ-020 valid_d SHALL equal queue-not-empty; a pop SHALL occur when valid_d and ready_d are both high.
REQ-021 A push and a pop in the same cycle SHALL leave the queue count unchanged; a response arriving into an empty queue SHALL appear on valid_d in the following cycle, giving one cycle of latency.
REQ-022 When valid_d is low, instr_d SHALL be NOP_INSTR and pc_d and pcplus4_d SHALL be 0.
REQ-023 On redirect_valid, the next fetch PC SHALL be redirect_pc, the queue SHALL be emptied, no pop SHALL be counted, and no request SHALL be issued that cycle.
REQ-024 On redirect_valid, the in-flight count SHALL be moved into a drop counter; the next that-many responses, including one arriving in the redirect cycle, SHALL be discarded.
REQ-025 Redirect SHALL take priority over push, pop and request in the same cycle.
REQ-026 A redirect received while the drop counter is non-zero SHALL add the newly in-flight requests to the drop counter.
REQ-027 The outstanding counter SHALL increment on request acceptance and decrement on any response, dropped or not; simultaneous events SHALL net out.
REQ-028 A response arriving with outstanding == 0 is illegal and SHALL be flagged by an assertion.

Reset
REQ-029 While rst is low, the fetch PC SHALL be RESET_PC, the queue, outstanding and drop counters SHALL be 0, imem_req_valid and valid_d SHALL be 0, and instr_d SHALL be NOP_INSTR.
REQ-030 Reset asserted mid-operation SHALL discard all queued and in-flight state; responses to pre-reset requests are the memory model's responsibility and SHALL NOT be accepted after reset.
REQ-031 The first request SHALL be issued in the first clk edge after rst deasserts, with address RESET_PC.

Structure
REQ-032 The NOP_INSTR default, the instruction width, and a fetch-entry struct {instr, pc, pcplus4} SHALL live in the shared core package.
REQ-033 The queue SHALL be one sub-module, fetch_fifo: parametrised width and depth, with push, pop, flush, count, full and empty, and flush taking priority.
REQ-034 The PC-tag FIFO SHALL be a second instance of fetch_fifo.

Verification
REQ-035 Reset release with ready_d=1 and a 1-cycle memory -> requests at 0x0, 0x4, 0x8; valid_d first high 2 cycles after the first accept, with pc_d=0x0 and pcplus4_d=0x4.
REQ-036 ready_d=0 for 10 cycles -> exactly DEPTH=4 instructions buffered, imem_req_valid low and no loss; after ready_d=1, pc_d is 0x0, 0x4, 0x8, 0xC in order.
REQ-037 Redirect to 0x100 with 2 requests in flight -> those 2 responses dropped, valid_d low until the response for 0x100 arrives, then pc_d=0x100.
REQ-038 Redirect in the same cycle as a response and a pop -> the response is dropped, the queue is empty next cycle, and the next request address is redirect_pc.
REQ-039 Fetch PC at 0xFFFF_FFFC -> the next request address is 0x0 and pcplus4_d for that entry is 0x0.
REQ-040 rst pulsed low with 3 entries queued -> valid_d=0 and instr_d=0x0000_0013 immediately (asynchronously); after release, the first request address is RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch path: instruction width, the NOP
// driven on an idle decode slot, and the entry held by the fetch queue.
package fetch_unit_pkg;

   localparam int unsigned CORE_XLEN = 32;
   localparam logic [CORE_XLEN-1:0] CORE_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [CORE_XLEN-1:0] instr;
      logic [CORE_XLEN-1:0] pc;
      logic [CORE_XLEN-1:0] pcplus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count; flush wins over push and pop.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone
   // decide which slots hold valid data.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential requests within an outstanding budget,
// tags responses with their PC, queues them for decode, and handles redirects.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned         XLEN      = CORE_XLEN,
   parameter int unsigned         DEPTH     = 4,
   parameter logic [XLEN-1:0]     RESET_PC  = '0,
   parameter logic [XLEN-1:0]     NOP_INSTR = XLEN'(CORE_NOP)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            valid_d,
   input  logic            ready_d,
   output logic [XLEN-1:0] instr_d,
   output logic [XLEN-1:0] pc_d,
   output logic [XLEN-1:0] pcplus4_d
);

   localparam int unsigned   CW     = $clog2(DEPTH) + 1;
   localparam int unsigned   EW     = 3 * XLEN;
   localparam logic [CW:0]   BUDGET = (CW+1)'(DEPTH);

   logic [XLEN-1:0] pc_q, pc_next;
   logic [CW-1:0]   drop_q, drop_next;
   logic [CW-1:0]   tag_count, q_count;
   logic            tag_full, tag_empty, q_full, q_empty;
   logic [XLEN-1:0] tag_pc;
   logic [EW-1:0]   q_din, q_head;
   logic            accept, rsp_pop, push_q, pop_q;

   // Outstanding requests are exactly the entries waiting in the tag FIFO.
   assign imem_req_valid = rst && !redirect_valid && !tag_full && !q_full &&
                           (({1'b0, tag_count} + {1'b0, q_count}) < BUDGET);
   assign imem_req_addr  = pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign rsp_pop = imem_rsp_valid && !tag_empty;
   assign push_q  = imem_rsp_valid && !redirect_valid && (drop_q == '0);
   assign pop_q   = valid_d && ready_d && !redirect_valid;
   assign q_din   = {imem_rsp_data, tag_pc, tag_pc + XLEN'(4)};

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned and
      // infers a latch.
      pc_next   = pc_q;
      drop_next = drop_q;
      if (redirect_valid) begin
         pc_next   = redirect_pc;
         drop_next = tag_count - CW'(rsp_pop);
      end else begin
         if (accept) pc_next = pc_q + XLEN'(4);
         if (imem_rsp_valid && drop_q != '0) drop_next = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_next;
         drop_q <= drop_next;
      end
   end

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (rsp_pop),
      .flush (1'b0),
      .din   (pc_q),
      .dout  (tag_pc),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_q),
      .pop   (pop_q),
      .flush (redirect_valid),
      .din   (q_din),
      .dout  (q_head),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   assign valid_d   = !q_empty;
   assign instr_d   = valid_d ? q_head[EW-1 -: XLEN]     : NOP_INSTR;
   assign pc_d      = valid_d ? q_head[2*XLEN-1 -: XLEN] : '0;
   assign pcplus4_d = valid_d ? q_head[XLEN-1:0]         : '0;

   // A response with nothing outstanding means the memory broke protocol.
   assert property (@(posedge clk) disable iff (!rst) imem_rsp_valid |-> !tag_empty);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a one-cycle in-order memory model, a table of
// start-up vectors, and hand-written stall, redirect, wrap and reset sequences.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = '0;
   logic        valid_d;
   logic        ready_d = 1'b1;
   logic [31:0] instr_d, pc_d, pcplus4_d;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .valid_d        (valid_d),
      .ready_d        (ready_d),
      .instr_d        (instr_d),
      .pc_d           (pc_d),
      .pcplus4_d      (pcplus4_d)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h5A00_0003;
   endfunction

   // Memory: a request accepted at edge n is answered during the cycle after edge n+1.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;
   pend_t       pend[$];
   int          cyc = 0;
   logic        acc_s = 1'b0;
   logic [31:0] addr_s = '0;

   always @(negedge clk) begin
      acc_s  = rst && imem_req_valid && imem_req_ready;
      addr_s = imem_req_addr;
   end

   always @(posedge clk) begin
      cyc++;
      if (acc_s && rst) pend.push_back('{addr_s, cyc + 1});
      #1;
      if (!rst) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = instr_of(pend[0].addr);
         pend.pop_front();
      end else begin
         imem_rsp_valid = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic rv, input logic [31:0] ra,
                            input logic v, input logic [31:0] pc);
      check({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, rv});
      if (rv) check({tag, ".req_addr"}, imem_req_addr, ra);
      check({tag, ".valid_d"}, {31'b0, valid_d}, {31'b0, v});
      check({tag, ".instr_d"}, instr_d, v ? instr_of(pc) : CORE_NOP);
      check({tag, ".pc_d"}, pc_d, v ? pc : 32'h0);
      check({tag, ".pcplus4_d"}, pcplus4_d, v ? pc + 32'h4 : 32'h0);
   endtask

   // Holds reset for three edges and releases it just after a rising edge.
   task automatic do_reset(input logic rdy);
      rst            = 1'b0;
      redirect_valid = 1'b0;
      ready_d        = rdy;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic         ready_d;
      logic         exp_rv;
      logic [31:0]  exp_ra;
      logic         exp_v;
      fetch_entry_t exp_e;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic rv, input logic [31:0] ra,
                               input logic v, input logic [31:0] pc);
      vec_t r;
      r.ready_d = rd;
      r.exp_rv  = rv;
      r.exp_ra  = ra;
      r.exp_v   = v;
      r.exp_e.instr   = v ? instr_of(pc) : CORE_NOP;
      r.exp_e.pc      = v ? pc : 32'h0;
      r.exp_e.pcplus4 = v ? pc + 32'h4 : 32'h0;
      return r;
   endfunction

   vec_t tbl[6];

   initial begin
      // Start-up with ready_d=1: one vector per cycle, vector 0 sits before the first edge.
      tbl[0] = mk(1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
      tbl[1] = mk(1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0);
      tbl[2] = mk(1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0);
      tbl[3] = mk(1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0);
      tbl[4] = mk(1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h4);
      tbl[5] = mk(1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h8);

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.req_valid", {31'b0, imem_req_valid}, 32'h0);
      check("rst.valid_d", {31'b0, valid_d}, 32'h0);
      check("rst.instr_d", instr_d, CORE_NOP);

      do_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) next_cycle();
         ready_d = tbl[i].ready_d;
         @(negedge clk);
         check($sformatf("v%0d.req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_rv});
         check($sformatf("v%0d.req_addr", i), imem_req_addr, tbl[i].exp_ra);
         check($sformatf("v%0d.valid_d", i), {31'b0, valid_d}, {31'b0, tbl[i].exp_v});
         check($sformatf("v%0d.instr_d", i), instr_d, tbl[i].exp_e.instr);
         check($sformatf("v%0d.pc_d", i), pc_d, tbl[i].exp_e.pc);
         check($sformatf("v%0d.pcplus4_d", i), pcplus4_d, tbl[i].exp_e.pcplus4);
      end

      // Decode stall: queue fills to DEPTH, requests stop, then drains in order.
      do_reset(1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_out("stall", 1'b0, 32'h0, 1'b1, 32'h0);
      next_cycle();
      ready_d = 1'b1;
      @(negedge clk);
      check_out("drain0", 1'b0, 32'h0, 1'b1, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("drain1", 1'b1, 32'h10, 1'b1, 32'h4);
      next_cycle();
      @(negedge clk);
      check_out("drain2", 1'b1, 32'h14, 1'b1, 32'h8);
      next_cycle();
      @(negedge clk);
      check_out("drain3", 1'b1, 32'h18, 1'b1, 32'hC);
      next_cycle();
      @(negedge clk);
      check_out("drain4", 1'b1, 32'h1C, 1'b1, 32'h10);

      // Redirect with two requests in flight; both responses are discarded.
      do_reset(1'b1);
      repeat (2) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      @(negedge clk);
      check_out("redir.cyc", 1'b0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      redirect_valid = 1'b0;
      @(negedge clk);
      check_out("redir.1", 1'b1, 32'h100, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("redir.2", 1'b1, 32'h104, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("redir.3", 1'b1, 32'h108, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("redir.4", 1'b1, 32'h10C, 1'b1, 32'h100);

      // Redirect coinciding with a response and a pending pop.
      do_reset(1'b1);
      repeat (4) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      @(negedge clk);
      check_out("coll.cyc", 1'b0, 32'h0, 1'b1, 32'h4);
      next_cycle();
      redirect_valid = 1'b0;
      @(negedge clk);
      check_out("coll.1", 1'b1, 32'h200, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("coll.2", 1'b1, 32'h204, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("coll.3", 1'b1, 32'h208, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("coll.4", 1'b1, 32'h20C, 1'b1, 32'h200);

      // PC wrap at the top of the address space.
      do_reset(1'b1);
      repeat (2) @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      next_cycle();
      redirect_valid = 1'b0;
      @(negedge clk);
      check_out("wrap.1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("wrap.2", 1'b1, 32'h0, 1'b0, 32'h0);
      repeat (2) next_cycle();
      @(negedge clk);
      check("wrap.valid_d", {31'b0, valid_d}, 32'h1);
      check("wrap.pc_d", pc_d, 32'hFFFF_FFFC);
      check("wrap.pcplus4_d", pcplus4_d, 32'h0);
      next_cycle();
      @(negedge clk);
      check_out("wrap.next", 1'b1, 32'hC, 1'b1, 32'h0);

      // Asynchronous reset with three entries queued.
      do_reset(1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_out("mid.before", 1'b0, 32'h0, 1'b1, 32'h0);
      #2 rst = 1'b0;
      #1;
      check_out("mid.async", 1'b0, 32'h0, 1'b0, 32'h0);
      ready_d = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check_out("mid.release", 1'b1, 32'h0, 1'b0, 32'h0);
      repeat (3) next_cycle();
      @(negedge clk);
      check_out("mid.first", 1'b1, 32'hC, 1'b1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
